fetch_queue: RTL and testbench

Instruction fetch front end of the pipelined ARM-subset CPU. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory. Returned words are buffered in a small prefetch queue and presented to the decode stage with a valid/stall handshake. Branch or PC-write redirects from writeback flush the queue and discard in-flight responses.

---
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem requests,
// buffers returned words in a prefetch queue and flushes on redirect.
// Optional feature macro FETCH_PERF_EN adds the PerfFetched/PerfBubble counters.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        StallD,
  output logic        InstrValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PC
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] PerfFetched,
  output logic [31:0] PerfBubble
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_FLUSH} state_t;

  state_t          state, state_next;
  logic [31:0]     pc, hpc;
  logic [31:0]     redirect_pc;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, out_cnt, disc;
  logic [CW-1:0]   out_next, disc_next;
  logic [CW:0]     used;
  logic            grant, drop, push, pop;

  // Queued entries plus in-flight requests never exceed DEPTH, so a push can't overflow.
  assign used        = {1'b0, count} + {1'b0, out_cnt};
  assign imem_req    = !reset && (used < CREDITS);
  assign grant       = imem_req && imem_gnt;
  assign redirect_pc = RedirectPC & 32'hFFFF_FFFC;

  assign InstrValidD = (count != '0);
  assign InstrD      = InstrValidD ? mem[rd_ptr] : 32'h0;
  assign PCD         = hpc;
  assign PC          = pc;
  assign imem_addr   = pc;

  always_comb begin
    state_next = state;
    drop       = 1'b0;
    out_next   = out_cnt + CW'(grant) - CW'(imem_rvalid);
    disc_next  = disc;

    case (state)
      S_FLUSH: drop = 1'b1;
      default: drop = 1'b0;
    endcase

    // Everything granted before the redirect settles as stale, including this cycle's grant.
    if (Redirect)
      disc_next = out_next;
    else if (imem_rvalid && drop)
      disc_next = disc - CW'(1);

    push = imem_rvalid && !Redirect && !drop;
    pop  = InstrValidD && !StallD && !Redirect;

    case (state)
      S_RESET: state_next = (disc_next != '0) ? S_FLUSH : S_FETCH;
      S_FETCH: if (disc_next != '0) state_next = S_FLUSH;
      S_FLUSH: if (disc_next == '0) state_next = S_FETCH;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      hpc     <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      out_cnt <= '0;
      disc    <= '0;
    end else begin
      out_cnt <= out_next;
      disc    <= disc_next;
      if (Redirect) begin
        pc     <= redirect_pc;
        hpc    <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (push)  wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          hpc    <= hpc + 32'd4;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage carries no reset; InstrD is masked by InstrValidD instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= imem_rdata;
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PerfFetched <= 32'h0;
      PerfBubble  <= 32'h0;
    end else begin
      if (pop)                    PerfFetched <= sat_inc(PerfFetched);
      if (!InstrValidD && !StallD) PerfBubble  <= sat_inc(PerfBubble);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: latency-configurable memory model, fetch-order scoreboard,
// cycle table for the startup/stall sequences, and hand-written redirect/reset cases.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        Redirect, StallD, InstrValidD;
  logic [31:0] RedirectPC, InstrD, PCD, PC;
`ifdef FETCH_PERF_EN
  logic [31:0] PerfFetched, PerfBubble;
  int          pf, pb;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .StallD(StallD),
    .InstrValidD(InstrValidD), .InstrD(InstrD), .PCD(PCD), .PC(PC)
`ifdef FETCH_PERF_EN
    , .PerfFetched(PerfFetched), .PerfBubble(PerfBubble)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;
  typedef struct { bit rst; bit stall; bit req; logic [31:0] addr; bit valid; logic [31:0] pcd; } vec_t;

  exp_t        sb[$];
  rsp_t        pend[$];
  vec_t        tbl[17];
  int          cyc, lat, n_chk, n_pass;
  logic [31:0] model_pc;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pcd, s_instr;

  function automatic logic [31:0] fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1; StallD = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; Redirect = 1'b0; RedirectPC = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pend.delete(); sb.delete(); model_pc = RESET_PC; cyc = 0;
`ifdef FETCH_PERF_EN
    pf = 0; pb = 0;
`endif
  endtask

  // Called just after a rising edge; drives one cycle, samples at the falling edge.
  task automatic cycle(input bit stall, input bit gnt, input bit redir, input logic [31:0] rpc);
    exp_t e;
    StallD = stall; imem_gnt = gnt; Redirect = redir; RedirectPC = rpc;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = pend[0].data; void'(pend.pop_front());
    end
    #4;
    s_req = imem_req; s_addr = imem_addr; s_valid = InstrValidD; s_pcd = PCD; s_instr = InstrD;
    if (imem_req && gnt) begin
      check("grant_addr", imem_addr, model_pc);
      pend.push_back('{data: fn(imem_addr), due: cyc + lat});
      sb.push_back('{pc: model_pc, instr: fn(model_pc)});
      model_pc += 32'd4;
    end
`ifdef FETCH_PERF_EN
    if (!redir && InstrValidD && !stall) pf++;
    if (!InstrValidD && !stall) pb++;
`endif
    if (redir) begin
      sb.delete();
      model_pc = rpc & 32'hFFFF_FFFC;
    end else if (InstrValidD && !stall) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_instr: got pc %h instr %h, none expected (cycle %0d)", PCD, InstrD, cyc);
      end else begin
        e = sb.pop_front();
        check("pop_pcd", PCD, e.pc);
        check("pop_instr", InstrD, e.instr);
      end
    end
    @(posedge clk);
    #1 cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    n_chk = 0; n_pass = 0; lat = 1;
    //         rst   stall req   addr      valid pcd
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h14};

    do_reset();
    check("reset_pc", PC, RESET_PC);
    check("reset_pcd", PCD, RESET_PC);
    check("reset_instr", InstrD, 32'h0);

    // Startup with single-cycle memory, then the stall-until-full sequence.
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) begin do_reset(); lat = 1; end
      cycle(tbl[i].stall, 1'b1, 1'b0, 32'h0);
      check_b("tbl_req", s_req, tbl[i].req);
      check("tbl_addr", s_addr, tbl[i].addr);
      check_b("tbl_valid", s_valid, tbl[i].valid);
      check("tbl_pcd", s_pcd, tbl[i].pcd);
    end

    // Latency 3, two outstanding, redirect to an unaligned target.
    do_reset(); lat = 3;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h103);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_b("redir_req", s_req, 1'b1);
    check("redir_addr", s_addr, 32'h100);
    check_b("redir_flushed", s_valid, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_valid) begin
        found = 1'b1;
        check("redir_first_pcd", s_pcd, 32'h100);
        check("redir_first_instr", s_instr, fn(32'h100));
      end
    end
    if (!found) begin n_chk++; $display("FAIL redir_timeout: no instruction after redirect, required pc 00000100"); end

    // Redirect coinciding with a response, a grant and a pop in a steady stream.
    do_reset(); lat = 1;
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_b("stream_valid", s_valid, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'h200);
    found = 1'b0;
    for (int k = 1; k <= 8 && !found; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_valid) begin
        found = 1'b1;
        check("redir2_latency", k, 3);
        check("redir2_pcd", s_pcd, 32'h200);
      end
    end
    if (!found) begin n_chk++; $display("FAIL redir2_timeout: no instruction after redirect, required pc 00000200"); end

    // Reset asserted mid-cycle with the queue full.
    do_reset(); lat = 1;
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check_b("full_valid", s_valid, 1'b1);
    check_b("full_req", s_req, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_b("async_req", imem_req, 1'b0);
    check_b("async_valid", InstrValidD, 1'b0);
    check("async_instr", InstrD, 32'h0);
    check("async_pcd", PCD, RESET_PC);
    check("async_pc", PC, RESET_PC);
    check("async_addr", imem_addr, RESET_PC);
    @(posedge clk);
    #1 reset = 1'b0;
    pend.delete(); sb.delete(); model_pc = RESET_PC; cyc = 0;
`ifdef FETCH_PERF_EN
    pf = 0; pb = 0;
`endif
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("restart_pcd", s_pcd, RESET_PC + 32'd4);

    // Random grants, stalls and redirects at several latencies, then drain.
    for (int r = 1; r <= 3; r++) begin
      do_reset(); lat = r;
      for (int i = 0; i < 150; i++)
        cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 19) == 0), $urandom());
      repeat (30) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("drain_sb", sb.size(), 0);
      check_b("drain_valid", s_valid, 1'b0);
    end

`ifdef FETCH_PERF_EN
    do_reset(); lat = 1;
    check("perf_fetched_rst", PerfFetched, 32'h0);
    check("perf_bubble_rst", PerfBubble, 32'h0);
    for (int i = 0; i < 14; i++) cycle((i == 6 || i == 7), 1'b1, 1'b0, 32'h0);
    check("perf_fetched", PerfFetched, pf);
    check("perf_bubble", PerfBubble, pb);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
